// File: rtl/ppa_pkg.sv
// ppa_pkg: shared slice width default and sequencer state encoding.
package ppa_pkg;
    localparam int SLICE_W_DEF = 25;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/ppa_multiword_add_seq_bk_adder_slice.sv
// bk_adder_slice: combinational W-bit Brent-Kung prefix adder with carry in/out.
module bk_adder_slice #(
    parameter int W = 25
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    localparam int L = $clog2(W);

    always_comb begin
        logic [W-1:0] h;
        logic [W-1:0] g;
        logic [W-1:0] p;
        h = a ^ b;
        g = a & b;
        p = h;
        // cin folded into bit 0 so every g[i] becomes the carry out of bit i
        g[0] = g[0] | (h[0] & cin);
        for (int l = 0; l < L; l++)
            for (int i = 0; i < W; i++)
                if ((i + 1) % (2 << l) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p[i] = p[i] & p[i - (1 << l)];
                end
        for (int l = L - 1; l >= 0; l--)
            for (int i = 0; i < W; i++)
                if ((i + 1) % (2 << l) == (1 << l) && i >= (2 << l)) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p[i] = p[i] & p[i - (1 << l)];
                end
        s    = h ^ {g[W-2:0], cin};
        cout = g[W-1];
    end
endmodule

// File: rtl/ppa_multiword_add_seq.sv
// ppa_multiword_add_seq: N-bit add/subtract done one SLICE_W-bit word per cycle
// through a single time-shared Brent-Kung slice, with valid/ready handshakes.
module ppa_multiword_add_seq
    import ppa_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF,
    parameter int NWORDS  = 4,
    localparam int N      = SLICE_W * NWORDS,
    localparam int KW     = $clog2(NWORDS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    state_e state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [N-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [SLICE_W-1:0] s;
    logic co;

    bk_adder_slice #(.W(SLICE_W)) u_slice (
        .a    (a_q[int'(k_q)*SLICE_W +: SLICE_W]),
        .b    (b_q[int'(k_q)*SLICE_W +: SLICE_W]),
        .cin  (c_q),
        .s    (s),
        .cout (co)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = op_sub ? ~b : b;
                c_d     = op_sub | cin;
                k_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[int'(k_q)*SLICE_W +: SLICE_W] = s;
                c_d = co;
                if (k_q == KW'(NWORDS - 1)) begin
                    k_d     = '0;
                    state_d = DONE;
                    cout_d  = co;
                    ovf_d   = (a_q[N-1] == b_q[N-1]) && (s[SLICE_W-1] != a_q[N-1]);
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_ppa_multiword_add_seq.sv
// tb_ppa_multiword_add_seq: directed table vectors plus hold and mid-run reset sequences.
module tb_ppa_multiword_add_seq;
    localparam int N = 100;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         sub;
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [N-1:0] a = '0, b = '0, sum;
    logic cin = 1'b0, op_sub = 1'b0, cout, ovf;
    int errors = 0, checks = 0;

    ppa_multiword_add_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request, check latency and result, leave DUT in DONE (out_ready low).
    task automatic issue(input vec_t v, input string tag);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; op_sub = v.sub;
        chk({tag, " in_ready"}, N'(in_ready), N'(1));
        @(negedge clk);
        in_valid = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin; op_sub = ~v.sub;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, N'(cyc), N'(4));
        chk({tag, " sum"}, sum, v.sum);
        chk({tag, " cout"}, N'(cout), N'(v.cout));
        chk({tag, " ovf"}, N'(ovf), N'(v.ovf));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " idle out_valid"}, N'(out_valid), N'(0));
        chk({tag, " idle in_ready"}, N'(in_ready), N'(1));
    endtask

    function automatic vec_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c, input logic s);
        vec_t v;
        logic [N:0] t;
        logic [N-1:0] yb;
        yb = s ? ~y : y;
        t = {1'b0, x} + {1'b0, yb} + (N+1)'(s | c);
        v = '{x, y, c, s, t[N-1:0], t[N], (x[N-1] == yb[N-1]) && (t[N-1] != x[N-1])};
        return v;
    endfunction

    initial begin
        vec_t tbl[8];
        vec_t v;
        logic [N-1:0] one, ones, top;
        one  = 1;
        ones = '1;
        top  = one << 99;
        tbl[0] = '{(one << 25) - one, one, 1'b0, 1'b0, one << 25, 1'b0, 1'b0};
        tbl[1] = '{ones, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0};
        tbl[2] = '{N'(5), N'(7), 1'b1, 1'b1, ones - one, 1'b0, 1'b0};
        tbl[3] = '{top - one, one, 1'b0, 1'b0, top, 1'b0, 1'b1};
        tbl[4] = '{N'(10), N'(3), 1'b0, 1'b1, N'(7), 1'b1, 1'b0};
        tbl[5] = '{top, one, 1'b0, 1'b1, top - one, 1'b1, 1'b1};
        tbl[6] = '{top, top, 1'b0, 1'b0, '0, 1'b1, 1'b1};
        tbl[7] = '{'0, '0, 1'b1, 1'b0, one, 1'b0, 1'b0};

        #2;
        chk("reset in_ready", N'(in_ready), N'(1));
        chk("reset out_valid", N'(out_valid), N'(0));
        chk("reset sum", sum, '0);
        chk("reset cout", N'(cout), N'(0));
        chk("reset ovf", N'(ovf), N'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i], $sformatf("vec%0d", i));
            release_out($sformatf("vec%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            v = model({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                       1'($urandom), 1'($urandom));
            issue(v, $sformatf("rnd%0d", i));
            release_out($sformatf("rnd%0d", i));
        end

        // Stall in DONE while a new request is offered: result must hold, nothing captured.
        issue(tbl[3], "hold");
        in_valid = 1'b1; a = '0; b = '0; cin = 1'b1; op_sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold sum", sum, tbl[3].sum);
            chk("hold cout", N'(cout), N'(tbl[3].cout));
            chk("hold ovf", N'(ovf), N'(tbl[3].ovf));
            chk("hold in_ready", N'(in_ready), N'(0));
            chk("hold out_valid", N'(out_valid), N'(1));
        end
        in_valid = 1'b0;
        release_out("hold");
        issue(tbl[4], "after_hold");
        release_out("after_hold");

        // Reset mid-RUN at k=2: outputs must clear before any clock edge.
        issue(tbl[6], "pre_rst");
        release_out("pre_rst");
        @(negedge clk);
        in_valid = 1'b1; a = ones; b = '0; cin = 1'b0; op_sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid-run sum nonzero", N'(sum != '0), N'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async rst in_ready", N'(in_ready), N'(1));
        chk("async rst out_valid", N'(out_valid), N'(0));
        chk("async rst sum", sum, '0);
        chk("async rst cout", N'(cout), N'(0));
        chk("async rst ovf", N'(ovf), N'(0));
        @(negedge clk);
        rst_n = 1'b1;
        issue(tbl[0], "post_rst");
        release_out("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
